// File: rtl/fe_pkg.sv
// Shared types for the front-end multicycle control unit: FSM states,
// decoded opcode classes and datapath mux selects.
package fe_pkg;

  typedef enum logic [2:0] {
    FETCH,
    DECODE,
    EXECUTE,
    MEM,
    WRITEBACK,
    TRAP
  } MC_STATE_t;

  typedef enum logic [2:0] {
    OP_R,
    OP_I,
    OP_LOAD,
    OP_STORE,
    OP_BRANCH,
    OP_JAL,
    OP_JALR,
    OP_ILLEGAL
  } OPCLASS_t;

  typedef enum logic [1:0] {A_RS1, A_PC, A_ZERO} ALU_A_SEL_t;
  typedef enum logic [1:0] {B_RS2, B_IMM, B_ZERO} ALU_B_SEL_t;
  typedef enum logic [1:0] {WB_ALU, WB_MEM, WB_PC_PLUS} WB_SEL_t;

  // Classes that produce a destination-register value.
  function automatic logic writes_rd(OPCLASS_t op);
    return op inside {OP_R, OP_I, OP_LOAD, OP_JAL, OP_JALR};
  endfunction

endpackage

// File: rtl/mc_control_unit_if.sv
// Signal bundle between mc_control_unit (master) and the decoder, ALU,
// register file and memories around it (slave).
interface mc_control_unit_if #(
  parameter int XLEN = 32
);
  // Memory handshakes: a request (imem_req / mem_req) stays high until the
  // cycle its ready is seen high; that cycle completes the transfer.
  // A ready without a request is ignored.
  logic [2:0]      opcode_class;
  logic            branch_taken;
  logic [XLEN-1:0] alu_out;
  logic            imem_req;
  logic            imem_ready;
  logic            ir_we;
  logic            mem_req;
  logic            mem_we;
  logic            mem_ready;
  logic [1:0]      alu_a_sel;
  logic [1:0]      alu_b_sel;
  logic            rf_we;
  logic [1:0]      wb_sel;
  logic [XLEN-1:0] pc;
  logic [2:0]      state;
  logic            retire;
  logic            trap;

  modport master (
    input  opcode_class, branch_taken, alu_out, imem_ready, mem_ready,
    output imem_req, ir_we, mem_req, mem_we, alu_a_sel, alu_b_sel,
           rf_we, wb_sel, pc, state, retire, trap
  );

  modport slave (
    output opcode_class, branch_taken, alu_out, imem_ready, mem_ready,
    input  imem_req, ir_we, mem_req, mem_we, alu_a_sel, alu_b_sel,
           rf_we, wb_sel, pc, state, retire, trap
  );
endinterface

// File: rtl/mc_stall_watchdog.sv
// Counts consecutive stalled cycles and flags the cycle in which the
// STALL_LIMIT-th stall occurs. STALL_LIMIT=0 disables it.
module mc_stall_watchdog #(
  parameter int STALL_LIMIT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic stall,
  input  logic clear,
  output logic expired
);
  localparam int CW = (STALL_LIMIT > 1) ? $clog2(STALL_LIMIT) : 1;

  logic [CW-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      cnt_q <= '0;
    end else if (stall && (STALL_LIMIT != 0)) begin
      cnt_q <= cnt_q + CW'(1);
    end
  end

  // Expiry forces a state change, so the counter never runs past the limit.
  assign expired = (STALL_LIMIT != 0) && stall && (int'(cnt_q) == STALL_LIMIT - 1);

endmodule

// File: rtl/mc_control_unit.sv
// Multicycle RV32I-style control FSM: FETCH/DECODE/EXECUTE/MEM/WRITEBACK with
// memory stalls, local PC+step, stall watchdog and a sticky TRAP state.
module mc_control_unit
  import fe_pkg::*;
#(
  parameter int              XLEN         = 32,
  parameter int              PC_STEP      = 4,
  parameter logic [XLEN-1:0] RESET_VECTOR = '0,
  parameter int              STALL_LIMIT  = 255
) (
  input  logic              clk,
  input  logic              rst,
  mc_control_unit_if.master bus
);

  MC_STATE_t       state_q, state_d;
  OPCLASS_t        op_q, dec_op;
  logic [XLEN-1:0] pc_q, pc_plus_q, alu_q, next_pc;
  logic            taken_q;
  logic            misaligned, retire_evt, pc_load;
  logic            wd_stall, wd_expired;
  logic            imem_req, ir_we, mem_req, mem_we, rf_we, retire;
  ALU_A_SEL_t      alu_a_sel;
  ALU_B_SEL_t      alu_b_sel;
  WB_SEL_t         wb_sel;

  assign dec_op = OPCLASS_t'(bus.opcode_class);

  always_comb begin
    next_pc = pc_plus_q;
    if (op_q == OP_JAL || (op_q == OP_BRANCH && taken_q)) begin
      next_pc = alu_q;
    end else if (op_q == OP_JALR) begin
      next_pc = {alu_q[XLEN-1:1], 1'b0};
    end
  end

  assign misaligned = (next_pc % XLEN'(PC_STEP)) != '0;
  assign wd_stall   = (state_q == FETCH && !bus.imem_ready) ||
                      (state_q == MEM   && !bus.mem_ready);

  mc_stall_watchdog #(
    .STALL_LIMIT(STALL_LIMIT)
  ) u_watchdog (
    .clk     (clk),
    .rst     (rst),
    .stall   (wd_stall),
    .clear   (state_d != state_q),
    .expired (wd_expired)
  );

  always_comb begin
    state_d    = state_q;
    imem_req   = 1'b0;
    ir_we      = 1'b0;
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    rf_we      = 1'b0;
    retire     = 1'b0;
    retire_evt = 1'b0;
    pc_load    = 1'b0;
    alu_a_sel  = A_RS1;
    alu_b_sel  = B_RS2;
    wb_sel     = WB_ALU;

    unique case (state_q)
      FETCH: begin
        imem_req = 1'b1;
        if (bus.imem_ready) begin
          ir_we   = 1'b1;
          state_d = DECODE;
        end else if (wd_expired) begin
          state_d = TRAP;
        end
      end
      DECODE: begin
        state_d = (dec_op == OP_ILLEGAL) ? TRAP : EXECUTE;
      end
      EXECUTE: begin
        unique case (op_q)
          OP_R:              begin alu_a_sel = A_RS1; alu_b_sel = B_RS2; end
          OP_BRANCH, OP_JAL: begin alu_a_sel = A_PC;  alu_b_sel = B_IMM; end
          default:           begin alu_a_sel = A_RS1; alu_b_sel = B_IMM; end
        endcase
        state_d = (op_q == OP_LOAD || op_q == OP_STORE) ? MEM : WRITEBACK;
      end
      MEM: begin
        mem_req = 1'b1;
        mem_we  = (op_q == OP_STORE);
        if (bus.mem_ready) begin
          if (op_q == OP_STORE) retire_evt = 1'b1;
          else                  state_d    = WRITEBACK;
        end else if (wd_expired) begin
          state_d = TRAP;
        end
      end
      WRITEBACK: begin
        rf_we      = writes_rd(op_q);
        retire_evt = 1'b1;
        if (op_q == OP_LOAD)                         wb_sel = WB_MEM;
        else if (op_q == OP_JAL || op_q == OP_JALR)  wb_sel = WB_PC_PLUS;
      end
      TRAP: state_d = TRAP;
      default: state_d = TRAP;
    endcase

    // A misaligned target turns the would-be retire into a trap.
    if (retire_evt) begin
      if (misaligned) begin
        state_d = TRAP;
        rf_we   = 1'b0;
      end else begin
        retire  = 1'b1;
        pc_load = 1'b1;
        state_d = FETCH;
      end
    end

    if (rst) begin
      imem_req = 1'b0;
      ir_we    = 1'b0;
      mem_req  = 1'b0;
      mem_we   = 1'b0;
      rf_we    = 1'b0;
      retire   = 1'b0;
      pc_load  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= FETCH;
      pc_q      <= RESET_VECTOR;
      pc_plus_q <= RESET_VECTOR;
      alu_q     <= '0;
      taken_q   <= 1'b0;
      op_q      <= OP_R;
    end else begin
      state_q <= state_d;
      if (ir_we) pc_plus_q <= pc_q + XLEN'(PC_STEP);
      if (state_q == DECODE) op_q <= dec_op;
      if (state_q == EXECUTE) begin
        alu_q   <= bus.alu_out;
        taken_q <= bus.branch_taken;
      end
      if (pc_load) pc_q <= next_pc;
    end
  end

  assign bus.imem_req  = imem_req;
  assign bus.ir_we     = ir_we;
  assign bus.mem_req   = mem_req;
  assign bus.mem_we    = mem_we;
  assign bus.rf_we     = rf_we;
  assign bus.retire    = retire;
  assign bus.alu_a_sel = alu_a_sel;
  assign bus.alu_b_sel = alu_b_sel;
  assign bus.wb_sel    = wb_sel;
  assign bus.pc        = pc_q;
  assign bus.state     = state_q;
  assign bus.trap      = (state_q == TRAP) && !rst;

endmodule

// File: tb/tb_mc_control_unit.sv
// Bench for mc_control_unit: directed and randomized instructions compared
// against an instruction-level model of latency, strobes and PC.
module tb_mc_control_unit;

  localparam logic [2:0] C_R = 3'd0, C_I = 3'd1, C_LOAD = 3'd2, C_STORE = 3'd3;
  localparam logic [2:0] C_BRANCH = 3'd4, C_JAL = 3'd5, C_JALR = 3'd6, C_ILLEGAL = 3'd7;
  localparam int LIM = 8;

  typedef struct {
    int          cyc;
    int          n_imem;
    int          n_irwe;
    int          n_mem;
    int          n_memwe;
    int          n_rfwe;
    logic [1:0]  wb;
    logic [1:0]  a;
    logic [1:0]  b;
    logic        retired;
    logic        trapped;
    logic [31:0] pc;
  } obs_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  int          checks = 0;
  int          errors = 0;
  int          gcyc = 0;
  logic [31:0] model_pc = 32'h0;

  mc_control_unit_if #(.XLEN(32)) bus ();

  mc_control_unit #(
    .XLEN        (32),
    .PC_STEP     (4),
    .RESET_VECTOR(32'h0),
    .STALL_LIMIT (LIM)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Instruction-level reference: per-class latency plus wait cycles,
  // strobe counts, operand selects and resulting PC.
  function automatic obs_t model(input logic [2:0] op, input logic [31:0] alu, input logic tk,
                                 input int iw, input int mw, input logic [31:0] pc_in);
    obs_t        e;
    logic [31:0] target;
    bit          is_mem;
    e = '{default: 0};
    e.pc = pc_in;
    is_mem = (op == C_LOAD) || (op == C_STORE);
    if (iw >= LIM) begin
      e.cyc = LIM + 1; e.n_imem = LIM; e.trapped = 1'b1;
      return e;
    end
    e.n_imem = iw + 1;
    e.n_irwe = 1;
    if (op == C_ILLEGAL) begin
      e.cyc = iw + 3; e.trapped = 1'b1;
      return e;
    end
    if (op == C_R) begin e.a = 2'd0; e.b = 2'd0; end
    else if (op == C_BRANCH || op == C_JAL) begin e.a = 2'd1; e.b = 2'd1; end
    else begin e.a = 2'd0; e.b = 2'd1; end
    if (is_mem && mw >= LIM) begin
      e.cyc = iw + 3 + LIM + 1; e.n_mem = LIM;
      e.n_memwe = (op == C_STORE) ? LIM : 0; e.trapped = 1'b1;
      return e;
    end
    if (is_mem) begin
      e.n_mem = mw + 1;
      e.n_memwe = (op == C_STORE) ? mw + 1 : 0;
    end
    if (op == C_JAL || (op == C_BRANCH && tk)) target = alu;
    else if (op == C_JALR) target = alu & ~32'h1;
    else target = pc_in + 32'd4;
    e.cyc = iw + 3 + (is_mem ? mw + 1 : 0) + ((op == C_STORE) ? 0 : 1);
    if (target[1:0] != 2'b00) begin
      e.cyc = e.cyc + 1; e.trapped = 1'b1;
      return e;
    end
    e.retired = 1'b1;
    e.pc = target;
    if (op inside {C_R, C_I, C_LOAD, C_JAL, C_JALR}) begin
      e.n_rfwe = 1;
      e.wb = (op == C_LOAD) ? 2'd1 : (op == C_JAL || op == C_JALR) ? 2'd2 : 2'd0;
    end
    return e;
  endfunction

  // Plays one instruction: memories answer after iw / mw not-ready cycles.
  task automatic run_instr(input logic [2:0] op, input logic [31:0] alu, input logic tk,
                           input int iw, input int mw, output obs_t o);
    int fwait, mwait;
    bit done;
    o = '{default: 0};
    fwait = 0; mwait = 0; done = 0;
    bus.opcode_class = op; bus.alu_out = alu; bus.branch_taken = tk;
    while (!done && o.cyc < 60) begin
      @(negedge clk);
      o.cyc++;
      bus.imem_ready = bus.imem_req && (fwait >= iw);
      bus.mem_ready  = bus.mem_req && (mwait >= mw);
      #1;
      if (bus.imem_req) begin o.n_imem++; fwait++; end
      if (bus.mem_req)  begin o.n_mem++;  mwait++; end
      if (bus.ir_we)  o.n_irwe++;
      if (bus.mem_we) o.n_memwe++;
      if (bus.rf_we) begin o.n_rfwe++; o.wb = bus.wb_sel; end
      if (o.cyc == iw + 3) begin o.a = bus.alu_a_sel; o.b = bus.alu_b_sel; end
      if (bus.retire) begin o.retired = 1'b1; done = 1; end
      if (bus.trap)   begin o.trapped = 1'b1; done = 1; end
    end
    @(posedge clk); #1;
    bus.imem_ready = 1'b0; bus.mem_ready = 1'b0;
    o.pc = bus.pc;
  endtask

  task automatic run_check(input string tag, input logic [2:0] op, input logic [31:0] alu,
                           input logic tk, input int iw, input int mw);
    obs_t e, o;
    e = model(op, alu, tk, iw, mw, model_pc);
    run_instr(op, alu, tk, iw, mw, o);
    chk({tag, ".cycles"},  o.cyc,     e.cyc);
    chk({tag, ".imem_req"}, o.n_imem, e.n_imem);
    chk({tag, ".ir_we"},   o.n_irwe,  e.n_irwe);
    chk({tag, ".mem_req"}, o.n_mem,   e.n_mem);
    chk({tag, ".mem_we"},  o.n_memwe, e.n_memwe);
    chk({tag, ".rf_we"},   o.n_rfwe,  e.n_rfwe);
    chk({tag, ".wb_sel"},  o.wb,      e.wb);
    chk({tag, ".retire"},  o.retired, e.retired);
    chk({tag, ".trap"},    o.trapped, e.trapped);
    chk({tag, ".pc"},      o.pc,      e.pc);
    if (op != C_ILLEGAL && iw < LIM) begin
      chk({tag, ".a_sel"}, o.a, e.a);
      chk({tag, ".b_sel"}, o.b, e.b);
    end
    model_pc = e.pc;
    gcyc += o.cyc;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; bus.imem_ready = 1'b0; bus.mem_ready = 1'b0;
    #1;
    chk("rst.strobes_pre", {bus.imem_req, bus.ir_we, bus.mem_req, bus.mem_we,
                            bus.rf_we, bus.retire, bus.trap}, 32'h0);
    @(posedge clk); #1;
    chk("rst.strobes", {bus.imem_req, bus.ir_we, bus.mem_req, bus.mem_we,
                        bus.rf_we, bus.retire, bus.trap}, 32'h0);
    chk("rst.state", bus.state, 32'd0);
    chk("rst.pc", bus.pc, 32'h0);
    rst = 1'b0;
    model_pc = 32'h0;
    gcyc = 0;
  endtask

  initial begin
    logic [2:0]  op;
    logic [31:0] r, alu;
    int          n_rf;

    bus.opcode_class = C_R; bus.branch_taken = 1'b0; bus.alu_out = '0;
    bus.imem_ready = 1'b0; bus.mem_ready = 1'b0;

    do_reset();

    run_check("addi", C_I, 32'h123, 1'b0, 0, 0);
    chk("addi.retire_at", gcyc, 4);
    run_check("lw", C_LOAD, 32'h200, 1'b0, 0, 0);
    chk("lw.retire_at", gcyc, 9);
    run_check("sw", C_STORE, 32'h204, 1'b0, 0, 0);
    chk("sw.retire_at", gcyc, 13);
    run_check("jal", C_JAL, 32'h2C, 1'b0, 0, 0);
    chk("jal.retire_at", gcyc, 17);
    chk("jal.pc_abs", bus.pc, 32'h2C);

    run_check("beq_taken", C_BRANCH, 32'h40, 1'b1, 0, 0);
    chk("beq_taken.pc_abs", bus.pc, 32'h40);
    run_check("beq_not", C_BRANCH, 32'h80, 1'b0, 0, 0);
    chk("beq_not.pc_abs", bus.pc, 32'h44);
    run_check("lw_wait", C_LOAD, 32'h300, 1'b0, 0, 3);

    for (int i = 0; i < 40; i++) begin
      op = 3'($urandom_range(0, 6));
      r  = $urandom();
      if (op == C_JAL || op == C_BRANCH) alu = r & ~32'h3;
      else if (op == C_JALR) alu = (r & ~32'h3) | {31'b0, r[0]};
      else alu = r;
      run_check($sformatf("rnd%0d", i), op, alu, 1'($urandom_range(0, 1)),
                $urandom_range(0, 3), $urandom_range(0, 3));
    end

    // Reset in the second MEM cycle of a LOAD.
    bus.opcode_class = C_LOAD; bus.alu_out = 32'h500;
    n_rf = 0;
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      bus.imem_ready = bus.imem_req; bus.mem_ready = 1'b0;
      #1;
      if (bus.rf_we) n_rf++;
    end
    chk("rstmem.in_mem", bus.state, 32'd3);
    rst = 1'b1; bus.imem_ready = 1'b0;
    #1;
    chk("rstmem.rf_we", bus.rf_we, 32'd0);
    chk("rstmem.mem_req", bus.mem_req, 32'd0);
    @(posedge clk); #1;
    chk("rstmem.state", bus.state, 32'd0);
    chk("rstmem.pc", bus.pc, 32'h0);
    chk("rstmem.no_write", n_rf, 0);
    rst = 1'b0; model_pc = 32'h0;

    run_check("jal_top", C_JAL, 32'hFFFF_FFFC, 1'b0, 0, 0);
    run_check("addi_wrap", C_I, 32'h7, 1'b0, 0, 0);
    chk("addi_wrap.pc_abs", bus.pc, 32'h0);

    run_check("jalr_mis", C_JALR, 32'h103, 1'b0, 0, 0);
    repeat (3) @(negedge clk);
    chk("trap.flag", bus.trap, 32'd1);
    chk("trap.imem_req", bus.imem_req, 32'd0);
    chk("trap.retire", bus.retire, 32'd0);
    chk("trap.state", bus.state, 32'd5);
    chk("trap.pc_frozen", bus.pc, model_pc);
    do_reset();

    run_check("illegal", C_ILLEGAL, 32'h0, 1'b0, 1, 0);
    do_reset();

    run_check("wd_fetch", C_I, 32'h0, 1'b0, 100, 0);
    chk("wd_fetch.pc_abs", bus.pc, 32'h0);
    do_reset();

    run_check("wd_mem", C_LOAD, 32'h10, 1'b0, 0, 100);
    do_reset();
    run_check("after_rst", C_R, 32'h0, 1'b0, 0, 0);
    chk("after_rst.pc_abs", bus.pc, 32'h4);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mc_control_unit.md
Name: mc_control_unit

Overview:
- Parametrised successor to the four-state RV32I multicycle control FSM.
- Sequences FETCH / DECODE / EXECUTE / MEM / WRITEBACK, with valid/ready stalls on instruction and data memory.
- Owns the PC register and computes PC+step locally, so the ALU is free in FETCH.
- Adds a stall watchdog, misaligned-target detection and a sticky TRAP state.
- Sits in fe/ between the decoder and the be/ ALU, register file and LSU.

Parameters:
XLEN, 32, datapath and PC width
PC_STEP, 4, PC increment per sequential instruction
RESET_VECTOR, 0, PC value loaded on reset
STALL_LIMIT, 255, maximum consecutive not-ready cycles in FETCH or MEM before TRAP; 0 disables the watchdog

Ports:
clk  in  1  clock
rst  in  1  reset
opcode_class  in  3  decoded class {R, I, LOAD, STORE, BRANCH, JAL, JALR, ILLEGAL}, valid in DECODE
branch_taken  in  1  ALU compare result, sampled in EXECUTE
alu_out  in  XLEN  ALU result
imem_req  out  1  instruction fetch request
imem_ready  in  1  instruction word available this cycle
ir_we  out  1  instruction register load strobe
mem_req  out  1  data memory request
mem_we  out  1  data memory write (store)
mem_ready  in  1  data access completes this cycle
alu_a_sel  out  2  {RS1, PC, ZERO}
alu_b_sel  out  2  {RS2, IMM, ZERO}
rf_we  out  1  register file write strobe
wb_sel  out  2  {ALU, MEM, PC_PLUS}
pc  out  XLEN  current PC
state  out  3  current FSM state
retire  out  1  one-cycle pulse when an instruction completes
trap  out  1  high while in TRAP

Interface rule: one clock, clk; reset rst is synchronous, active-high.

Behaviour:
Reset:
- On rst high at a clk edge: state=FETCH, pc=RESET_VECTOR, watchdog=0, latched ALU result alu_q=0.
- While rst is high, every strobe is forced 0: imem_req, ir_we, mem_req, mem_we, rf_we, retire, trap.
- rst mid-operation aborts the instruction with no register-file write.

FETCH:
- imem_req=1, held until imem_ready.
- On the imem_ready cycle: ir_we=1, pc_plus <= pc+PC_STEP, next state DECODE.

DECODE (1 cycle):
- opcode_class=ILLEGAL -> TRAP; otherwise -> EXECUTE.

EXECUTE (1 cycle):
- Operand selects:
  - R: RS1 / RS2
  - I, LOAD, STORE, JALR: RS1 / IMM
  - BRANCH, JAL: PC / IMM
- alu_q <= alu_out; taken_q <= branch_taken.
- Next state: LOAD or STORE -> MEM; otherwise -> WRITEBACK.

MEM:
- mem_req=1, with mem_we=1 for STORE; held until mem_ready.
- LOAD -> WRITEBACK.
- STORE -> FETCH with retire=1 and pc <= pc_plus.

WRITEBACK (1 cycle):
- Register write: rf_we=1 for R, I, LOAD, JAL, JALR.
- wb_sel: MEM for LOAD, PC_PLUS for JAL/JALR, ALU otherwise.
- retire=1; next state FETCH.

PC update (in the retire cycle only):
- next_pc = alu_q for JAL, for BRANCH with taken_q, and for JALR (bit 0 cleared).
- next_pc = pc_plus otherwise.
- If next_pc mod PC_STEP != 0: TRAP instead; no retire, no rf_we.

Watchdog:
- Increments in FETCH or MEM while the ready input is low.
- Clears on any state change.
- Reaching STALL_LIMIT (when nonzero) -> TRAP, requests dropped.

TRAP:
- Sticky; trap=1; all strobes 0; pc frozen. Only rst exits.

Widths:
- PC arithmetic is modulo 2^XLEN; pc+PC_STEP wraps silently from all-ones.

Latency (zero-wait memory):
- ALU/JAL/branch: 4 cycles.
- LOAD: 5 cycles.
- STORE: 4 cycles.
- Each not-ready cycle adds one.

Decomposition:
- fe_pkg holds the shared types: MC_STATE_t {FETCH, DECODE, EXECUTE, MEM, WRITEBACK, TRAP}, OPCLASS_t, ALU_A_SEL_t, ALU_B_SEL_t, WB_SEL_t.
- One natural sub-module: mc_stall_watchdog (counter, clear, limit compare, parameter STALL_LIMIT).
- All remaining logic is flat in mc_control_unit.

Test Plan:
- Zero-wait mix ADDI, LW, SW, JAL -> retire pulses at cycles 4, 9, 13, 17 after reset release; pc 0 -> 4 -> 8 -> 0xC -> 0xC+imm.
- BEQ with branch_taken=1, alu_out=0x40 -> pc=0x40 at retire. Same with branch_taken=0 -> pc=pc+4, rf_we never asserted.
- LW with mem_ready low for 3 cycles -> mem_req held for 4 cycles; rf_we with wb_sel=MEM exactly once; retire 3 cycles later than zero-wait.
- STALL_LIMIT=8, imem_ready stuck low -> TRAP entered after 8 cycles, trap=1, imem_req=0. rst pulse -> FETCH, pc=RESET_VECTOR.
- JALR with alu_out=0x103 -> pc=0x102 fails alignment -> TRAP, no rf_we. ILLEGAL class in DECODE -> TRAP in the next cycle.
- RESET_VECTOR=0xFFFFFFFC, sequential ADDI -> pc wraps to 0x0; rst asserted mid-MEM -> no rf_we, state=FETCH on the following edge.
